// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags and optional iterative MUL/DIVU/REMU.
// Define ALU_MULDIV_EN to build the multi-cycle multiply/divide datapath.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic             accept, multi;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_ill;

`ifdef ALU_MULDIV_EN
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q, hi_n, lo_n, md_res;
    logic [WIDTH:0]   md_sum, md_rem;
    logic [SHW-1:0]   cnt_q;
    logic             mul_q, rem_q, md_c;
`endif

    assign sh        = op_b[SHW-1:0];
    assign out_valid = (state == DONE);

    always_comb begin
        multi = 1'b0;
`ifdef ALU_MULDIV_EN
        multi = (opcode == 4'd9) || (opcode == 4'd10) || (opcode == 4'd11);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE) || (state == DONE && out_ready);
        accept     = in_valid && in_ready;
        case (state)
            IDLE: if (accept) state_next = multi ? BUSY : DONE;
            BUSY: begin
`ifdef ALU_MULDIV_EN
                if (cnt_q == '0) state_next = DONE;
`endif
            end
            DONE: begin
                if (accept)         state_next = multi ? BUSY : DONE;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shifts keep one extra bit beside the word so the last bit out lands in alu_c.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (opcode)
            4'd0: begin
                {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
                alu_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd1: begin
                alu_res = op_a - op_b;
                alu_c   = op_a < op_b;
                alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd2: alu_res = op_a & op_b;
            4'd3: alu_res = op_a | op_b;
            4'd4: alu_res = op_a ^ op_b;
            4'd5: alu_res = ~op_a;
            4'd6: {alu_c, alu_res} = {1'b0, op_a} << sh;
            4'd7: {alu_res, alu_c} = {op_a, 1'b0} >> sh;
            4'd8: {alu_res, alu_c} = $signed({op_a, 1'b0}) >>> sh;
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // One shift-add or restoring-division step; divide by zero naturally yields all-ones / op_a.
    always_comb begin
        md_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        md_rem = {hi_q, lo_q[WIDTH-1]};
        if (mul_q) begin
            hi_n = md_sum[WIDTH:1];
            lo_n = {md_sum[0], lo_q[WIDTH-1:1]};
        end else if (md_rem >= {1'b0, opnd_q}) begin
            hi_n = WIDTH'(md_rem - {1'b0, opnd_q});
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = md_rem[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end
        md_res = (mul_q || !rem_q) ? lo_n : hi_n;
        md_c   = mul_q ? (hi_n != '0) : (opnd_q == '0);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
`ifdef ALU_MULDIV_EN
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            mul_q  <= 1'b0;
            rem_q  <= 1'b0;
`endif
        end else begin
            if (accept && !multi) begin
                result   <= alu_res;
                zero     <= (alu_res == '0);
                negative <= alu_res[WIDTH-1];
                carry    <= alu_c;
                overflow <= alu_v;
                illegal  <= alu_ill;
            end
`ifdef ALU_MULDIV_EN
            if (accept && multi) begin
                hi_q   <= '0;
                lo_q   <= op_a;
                opnd_q <= op_b;
                cnt_q  <= SHW'(WIDTH - 1);
                mul_q  <= (opcode == 4'd9);
                rem_q  <= (opcode == 4'd11);
            end else if (state == BUSY) begin
                hi_q <= hi_n;
                lo_q <= lo_n;
                if (cnt_q == '0) begin
                    result   <= md_res;
                    zero     <= (md_res == '0);
                    negative <= md_res[WIDTH-1];
                    carry    <= md_c;
                    overflow <= 1'b0;
                    illegal  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH = 32); MUL/DIV steps follow ALU_MULDIV_EN.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [3:0]   opcode = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero, negative, carry, overflow, illegal;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
            $error("[TB] %s differs", tag);
        end
    endtask

    // Flags ordered {zero, negative, carry, overflow, illegal}; out_valid must be 1.
    task automatic expect_out(input string tag, input logic [W-1:0] r, input logic [4:0] f);
        check({tag, " result"}, result, r);
        check({tag, " valid+flags"}, {out_valid, zero, negative, carry, overflow, illegal}, {1'b1, f});
    endtask

    task automatic issue(input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
        opcode   = opc;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles, output int n);
        n = 0;
        while (!out_valid && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " out_valid before timeout"}, out_valid, 1'b1);
    endtask

    initial begin
        int n;
        logic busy_ready;
        logic [W-1:0] held_res;
        logic [5:0]   held_flags;

        #12;
        check("reset flags", {out_valid, zero, negative, carry, overflow, illegal}, 6'b0);
        check("reset result", result, 32'h0);
        check("reset in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(4'd0, 32'hFFFF_FFFF, 32'h1);  expect_out("add wrap", 32'h0, 5'b10100);
        issue(4'd0, 32'h7FFF_FFFF, 32'h1);  expect_out("add ovf", 32'h8000_0000, 5'b01010);
        issue(4'd1, 32'd3, 32'd5);          expect_out("sub borrow", 32'hFFFF_FFFE, 5'b01100);
        issue(4'd1, 32'h8000_0000, 32'h1);  expect_out("sub ovf", 32'h7FFF_FFFF, 5'b00010);
        issue(4'd8, 32'h8000_0000, 32'd4);  expect_out("sra", 32'hF800_0000, 5'b01000);
        issue(4'd6, 32'h8000_0001, 32'd1);  expect_out("shl", 32'h0000_0002, 5'b00100);
        issue(4'd7, 32'h0000_0003, 32'h101); expect_out("shr upper ignored", 32'h1, 5'b00100);
        issue(4'd6, 32'h8000_0000, 32'h20); expect_out("shl zero amount", 32'h8000_0000, 5'b01000);
        issue(4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F); expect_out("and", 32'h0F00_0F00, 5'b00000);
        issue(4'd3, 32'hFF00_FF00, 32'h0F0F_0F0F); expect_out("or", 32'hFF0F_FF0F, 5'b01000);
        issue(4'd5, 32'h0, 32'h1234);       expect_out("not", 32'hFFFF_FFFF, 5'b01000);
        issue(4'd13, 32'h5, 32'h5);         expect_out("illegal op", 32'h0, 5'b10001);

        // Back-pressure: hold the XOR result while ignored ops are offered.
        issue(4'd4, 32'hAAAA_5555, 32'h0000_FFFF);
        out_ready = 1'b0;
        expect_out("xor", 32'hAAAA_AAAA, 5'b01000);
        for (int i = 0; i < 5; i++) begin
            opcode = 4'd0; op_a = 32'h1; op_b = 32'h1; in_valid = 1'b1;
            @(posedge clk); #1;
            expect_out("xor held", 32'hAAAA_AAAA, 5'b01000);
            check("held in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("consumed out_valid", out_valid, 1'b0);

        // Four ADDs on consecutive edges.
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            opcode = 4'd0; op_a = 32'h100 * i; op_b = 32'd7;
            @(posedge clk); #1;
            check("b2b result", result, 32'h100 * i + 32'd7);
            check("b2b valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;

`ifdef ALU_MULDIV_EN
        opcode = 4'd9; op_a = 32'h0001_0000; op_b = 32'h0001_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        opcode = 4'd0; op_a = 32'h5; op_b = 32'hDEAD;
        n = 0;
        busy_ready = 1'b0;
        while (!out_valid && n < 40) begin
            busy_ready = busy_ready | in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("mul latency", n, 32);
        check("mul busy in_ready", busy_ready, 1'b0);
        expect_out("mul", 32'h0, 5'b10100);

        issue(4'd10, 32'd100, 32'd7);      wait_valid("divu", 40, n); expect_out("divu", 32'd14, 5'b00000);
        issue(4'd11, 32'd100, 32'd7);      wait_valid("remu", 40, n); expect_out("remu", 32'd2, 5'b00000);
        issue(4'd10, 32'h1234, 32'h0);     wait_valid("divu0", 40, n); expect_out("divu0", 32'hFFFF_FFFF, 5'b01100);
        issue(4'd11, 32'h1234, 32'h0);     wait_valid("remu0", 40, n); expect_out("remu0", 32'h1234, 5'b00100);

        issue(4'd9, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-mul reset valid", out_valid, 1'b0);
        check("mid-mul reset result", result, 32'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'd0, 32'd2, 32'd2);         expect_out("add after reset", 32'd4, 5'b00000);
`else
        issue(4'd9, 32'h0001_0000, 32'h0001_0000); expect_out("mul disabled", 32'h0, 5'b10001);
        issue(4'd10, 32'd100, 32'd7);              expect_out("divu disabled", 32'h0, 5'b10001);
`endif

        // Reset while a result is held discards it.
        issue(4'd4, 32'h0F0F_0F0F, 32'h0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        held_res   = result;
        held_flags = {out_valid, zero, negative, carry, overflow, illegal};
        check("pre-reset held result", held_res, 32'h0F0F_0F0F);
        rst_n = 1'b0;
        #1;
        check("done reset flags", {out_valid, zero, negative, carry, overflow, illegal}, 6'b0);
        check("done reset result", result, 32'h0);
        check("done reset in_ready", in_ready, 1'b1);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        issue(4'd0, 32'd2, 32'd2);         expect_out("add 2+2", 32'd4, 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
